// File: rtl/main_mem_responder.sv
// main_mem_responder
// Line-granular main-memory responder at the memory side of the cache miss/writeback
// handshake. One level-held line request (read or write) is accepted at a time and answered
// with a single-cycle ca_resp a fixed number of cycles after acceptance.
//
// Optional feature macro: MAIN_MEM_RAND_LAT_EN
//   When defined, an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) advances on every accept
//   and adds lfsr[1:0] to the latency (LATENCY..LATENCY+3).
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   mem_read   line read request, held until ca_resp
//   mem_write  line write request, held until ca_resp
//   mem_addr   byte address of the line (offset bits ignored, high bits alias)
//   mem_wdata  write line data
//   ca_resp    one-cycle completion pulse
//   mem_rdata  read line data, valid from ca_resp until the next accept
//   busy       high while a request is in flight (WAIT or RESP)
//   proto_err  sticky protocol-violation flag, cleared only by rst

module main_mem_responder #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic              ca_resp,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              busy,
    output logic              proto_err
);

    localparam int unsigned OffW = $clog2(LINE_W / 8);
    localparam int unsigned IdxW = $clog2(DEPTH);
    // Room for the largest load value, LATENCY+2, with margin.
    localparam int unsigned CntW = $clog2(LATENCY + 4);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e state_q, state_d;

    logic [IdxW-1:0]   idx_q;
    logic              wr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [CntW-1:0]   cnt_q;
    logic [CntW-1:0]   cnt_load;
    logic [LINE_W-1:0] rdata_q;
    logic              perr_q;

    logic [LINE_W-1:0] mem [DEPTH];

    logic            req;
    logic            accept;
    logic [IdxW-1:0] addr_idx;

    assign req      = mem_read | mem_write;
    assign accept   = (state_q == StIdle) && req;
    assign addr_idx = mem_addr[OffW +: IdxW];

    // Offset and high address bits are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{mem_addr[ADDR_W-1:OffW+IdxW], mem_addr[OffW-1:0]};

`ifdef MAIN_MEM_RAND_LAT_EN
    logic [7:0] lfsr_q;
    logic       lfsr_fb;

    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else if (accept) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_fb};
        end
    end

    // Latency uses the LFSR value present at accept, before it advances.
    assign cnt_load = CntW'(LATENCY - 1 + 32'(lfsr_q[1:0]));
`else
    assign cnt_load = CntW'(LATENCY - 1);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = (cnt_load == '0) ? StResp : StWait;
                end
            end
            StWait: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        ca_resp   = (state_q == StResp);
        busy      = (state_q != StIdle);
        mem_rdata = rdata_q;
        proto_err = perr_q;
    end

    // Request capture, latency counter, read data and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        idx_q   <= addr_idx;
                        wr_q    <= mem_write;  // write wins when both are set
                        wdata_q <= mem_wdata;
                        cnt_q   <= cnt_load;
                        if (mem_read && mem_write) begin
                            perr_q <= 1'b1;
                        end
                        // Zero-wait path enters RESP directly: read the live index.
                        if (cnt_load == '0 && !mem_write) begin
                            rdata_q <= mem[addr_idx];
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1) && !wr_q) begin
                        rdata_q <= mem[idx_q];
                    end
                    if (!req) begin
                        perr_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write commits on the edge leaving RESP; a reset at that edge discards it.
    always_ff @(posedge clk) begin
        if (!rst && state_q == StResp && wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
